// File: rtl/pfb_chan_pkg.sv
// Shared constants and helpers for the PFB MAC output path.
// Accumulator width, default sample formats, saturation limits.
package pfb_chan_pkg;

  localparam int P_W      = 48;
  localparam int OUT_W_D  = 16;
  localparam int SHIFT_D  = 15;
  localparam int CHAN_W_D = 6;

  function automatic logic signed [P_W-1:0] sat_lim(
    input int   w,
    input logic hi
  );
    logic signed [P_W-1:0] one;
    one = 48'sd1;
    return hi ? (one <<< (w-1)) - one
              : -(one <<< (w-1));
  endfunction

endpackage

// File: rtl/pfb_out_fifo.sv
// Small show-ahead FIFO holding rounded MAC results.
// Head word is presented combinationally whenever count is non-zero.
module pfb_out_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [W-1:0]               din,
  input  logic                       rd_en,
  output logic [W-1:0]               dout,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_rd;

  assign valid = (count != '0);
  assign do_rd = rd_en & valid;
  assign dout  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      assert (count != (AW+1)'(DEPTH))
        else $error("pfb_out_fifo: write while full");
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_rd)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pfb_mac_out_stage.sv
// PFB MAC chain output stage: ce/credit control, valid/user tracking,
// round + saturate of the accumulator, and a buffered AXI-Stream master.
module pfb_mac_out_stage
  import pfb_chan_pkg::*;
#(
  parameter int MAC_LATENCY = 4,
  parameter int OUT_W       = OUT_W_D,
  parameter int SHIFT       = SHIFT_D,
  parameter int CHAN_W      = CHAN_W_D,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [CHAN_W-1:0] s_axis_tuser,
  input  logic              s_axis_tlast,
  output logic              mac_ce,
  input  logic [P_W-1:0]    mac_p,
  output logic [OUT_W-1:0]  m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [CHAN_W-1:0] m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              sat_pulse
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int E_W   = OUT_W + CHAN_W + 1;
  localparam logic signed [P_W-1:0] RND =
    P_W'(64'd1 << (SHIFT-1));
  localparam logic signed [P_W-1:0] Q_MAX = sat_lim(OUT_W, 1'b1);
  localparam logic signed [P_W-1:0] Q_MIN = sat_lim(OUT_W, 1'b0);

  logic [MAC_LATENCY-1:0] vpipe;
  logic [MAC_LATENCY-1:0] lpipe;
  logic [CHAN_W-1:0]      upipe [MAC_LATENCY];

  logic                  rnd_valid;
  logic                  rnd_take;
  logic signed [P_W-1:0] rnd_p;
  logic [CHAN_W-1:0]     rnd_user;
  logic                  rnd_last;

  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        occ;
  logic                  space_ok;

  logic signed [P_W-1:0] sum;
  logic signed [P_W-1:0] q;
  logic [OUT_W-1:0]      sat_data;
  logic                  sat;
  logic [E_W-1:0]        wr_data;
  logic [E_W-1:0]        rd_data;

  // Credits count both stored entries and the one in the round register.
  assign occ      = {1'b0, fifo_count} + (CNT_W+1)'(rnd_valid);
  assign space_ok = occ < (CNT_W+1)'(FIFO_DEPTH);

  assign s_axis_tready = rst_n & space_ok;
  assign mac_ce        = rst_n & space_ok
                       & (s_axis_tvalid | (|vpipe));
  assign rnd_take      = mac_ce & vpipe[MAC_LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
      lpipe <= '0;
      for (int i = 0; i < MAC_LATENCY; i++)
        upipe[i] <= '0;
    end else if (mac_ce) begin
      vpipe[0] <= s_axis_tvalid;
      lpipe[0] <= s_axis_tlast;
      upipe[0] <= s_axis_tuser;
      for (int i = 1; i < MAC_LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
        lpipe[i] <= lpipe[i-1];
        upipe[i] <= upipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_valid <= 1'b0;
      rnd_p     <= '0;
      rnd_user  <= '0;
      rnd_last  <= 1'b0;
    end else begin
      rnd_valid <= rnd_take;
      if (rnd_take) begin
        rnd_p    <= mac_p;
        rnd_user <= upipe[MAC_LATENCY-1];
        rnd_last <= lpipe[MAC_LATENCY-1];
      end
    end
  end

  always_comb begin
    sum      = rnd_p + RND;
    q        = sum >>> SHIFT;
    sat      = 1'b0;
    sat_data = q[OUT_W-1:0];
    if (q > Q_MAX) begin
      sat_data = Q_MAX[OUT_W-1:0];
      sat      = 1'b1;
    end else if (q < Q_MIN) begin
      sat_data = Q_MIN[OUT_W-1:0];
      sat      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_pulse <= 1'b0;
    else
      sat_pulse <= rnd_valid & sat;
  end

  assign wr_data = {rnd_last, rnd_user, sat_data};

  pfb_out_fifo #(
    .W     (E_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (rnd_valid),
    .din   (wr_data),
    .rd_en (m_axis_tready),
    .dout  (rd_data),
    .valid (m_axis_tvalid),
    .count (fifo_count)
  );

  assign m_axis_tdata = rd_data[OUT_W-1:0];
  assign m_axis_tuser = rd_data[OUT_W +: CHAN_W];
  assign m_axis_tlast = rd_data[E_W-1];

endmodule
